// File: rtl/ctrl_cmd_pkg.sv
// rtl/ctrl_cmd_pkg.sv - command codes, widths and pulse encoder for the control arbiter
package ctrl_cmd_pkg;

    localparam int CMD_W = 3;
    localparam int SRC_W = 2;

    localparam logic [CMD_W-1:0] CMD_NONE  = 3'd0;
    localparam logic [CMD_W-1:0] CMD_UP    = 3'd1;
    localparam logic [CMD_W-1:0] CMD_DOWN  = 3'd2;
    localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd3;
    localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd4;
    localparam logic [CMD_W-1:0] CMD_START = 3'd5;

    // START outranks the directions so a game start is never lost to a stray move
    function automatic logic [CMD_W-1:0] encode(input logic up, input logic down,
                                                 input logic left, input logic right,
                                                 input logic start);
        if (start)      return CMD_START;
        else if (up)    return CMD_UP;
        else if (down)  return CMD_DOWN;
        else if (left)  return CMD_LEFT;
        else if (right) return CMD_RIGHT;
        else            return CMD_NONE;
    endfunction

    function automatic logic multi_hot(input logic [4:0] bits);
        return (bits & (bits - 5'd1)) != 5'd0;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous first-word-fall-through command FIFO
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // a push into a full FIFO is legal only when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_cmd_arbiter.sv
// rtl/ctrl_cmd_arbiter.sv - round-robin merge of per-source control pulses into one command stream
module ctrl_cmd_arbiter
    import ctrl_cmd_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_up,
    input  logic [NUM_SRC-1:0] src_down,
    input  logic [NUM_SRC-1:0] src_left,
    input  logic [NUM_SRC-1:0] src_right,
    input  logic [NUM_SRC-1:0] src_start,
    input  logic [NUM_SRC-1:0] src_en,
    output logic               cmd_valid,
    output logic [2:0]         cmd_code,
    output logic [1:0]         cmd_src,
    input  logic               cmd_ready,
    output logic [1:0]         dir_held,
    output logic               dir_held_valid,
    output logic [DROP_W-1:0]  drop_cnt,
    output logic [2:0]         fifo_level
);

    localparam int FW = SRC_W + CMD_W;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [CMD_W-1:0]   pending     [NUM_SRC];
    logic [CMD_W-1:0]   pending_nxt [NUM_SRC];
    logic [CMD_W-1:0]   code_in     [NUM_SRC];
    logic [NUM_SRC-1:0] multi;
    logic [NUM_SRC-1:0] ovwr;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   gnt_idx;
    logic [CMD_W-1:0]   gnt_code;
    logic               gnt_vld;

    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               can_push;
    logic [FW-1:0]      head;
    logic [LW-1:0]      fifo_lvl;
    logic [CMD_W-1:0]   head_code;

    logic [3:0]         drop_inc;
    logic [DROP_W+3:0]  drop_sum;
    logic [DROP_W+3:0]  drop_max;

    assign pop       = !fifo_empty && cmd_ready;
    assign can_push  = !fifo_full || pop;
    assign head_code = head[CMD_W-1:0];

    assign cmd_valid  = !fifo_empty;
    assign cmd_code   = fifo_empty ? CMD_NONE : head_code;
    assign cmd_src    = fifo_empty ? 2'd0 : head[FW-1:CMD_W];
    assign fifo_level = 3'(fifo_lvl);

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            code_in[i] = CMD_NONE;
            multi[i]   = 1'b0;
            if (src_en[i]) begin
                code_in[i] = encode(src_up[i], src_down[i], src_left[i], src_right[i], src_start[i]);
                multi[i]   = multi_hot({src_start[i], src_up[i], src_down[i], src_left[i], src_right[i]});
            end
        end
    end

    // search begins one past the last winner so every source gets a turn
    always_comb begin
        int idx;
        idx      = 0;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        gnt_code = CMD_NONE;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (!gnt_vld && can_push && pending[idx] != CMD_NONE) begin
                gnt_vld  = 1'b1;
                gnt_idx  = SRC_W'(idx);
                gnt_code = pending[idx];
            end
        end
    end

    always_comb begin
        drop_inc = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pending_nxt[i] = pending[i];
            ovwr[i]        = 1'b0;
            if (!src_en[i]) begin
                pending_nxt[i] = CMD_NONE;
            end else if (code_in[i] != CMD_NONE) begin
                pending_nxt[i] = code_in[i];
                ovwr[i] = (pending[i] != CMD_NONE) && !(gnt_vld && gnt_idx == SRC_W'(i));
            end else if (gnt_vld && gnt_idx == SRC_W'(i)) begin
                pending_nxt[i] = CMD_NONE;
            end
            drop_inc = drop_inc + 4'(multi[i]) + 4'(ovwr[i]);
        end
        drop_max = (DROP_W+4)'({DROP_W{1'b1}});
        drop_sum = (DROP_W+4)'(drop_cnt) + (DROP_W+4)'(drop_inc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                pending[i] <= CMD_NONE;
            end
            rr_ptr         <= SRC_W'(NUM_SRC - 1);
            dir_held       <= 2'd0;
            dir_held_valid <= 1'b0;
            drop_cnt       <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                pending[i] <= pending_nxt[i];
            end
            if (gnt_vld) begin
                rr_ptr <= gnt_idx;
            end
            if (pop && head_code >= CMD_UP && head_code <= CMD_RIGHT) begin
                dir_held       <= 2'(head_code - 3'd1);
                dir_held_valid <= 1'b1;
            end
            drop_cnt <= (drop_sum > drop_max) ? {DROP_W{1'b1}} : DROP_W'(drop_sum);
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (gnt_vld),
        .wdata ({gnt_idx, gnt_code}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_lvl)
    );

endmodule

// File: tb/tb_ctrl_cmd_arbiter.sv
// tb/tb_ctrl_cmd_arbiter.sv - directed scoreboard bench for ctrl_cmd_arbiter
module tb_ctrl_cmd_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] src_up, src_down, src_left, src_right, src_start, src_en;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [1:0] cmd_src;
    logic       cmd_ready;
    logic [1:0] dir_held;
    logic       dir_held_valid;
    logic [7:0] drop_cnt;
    logic [2:0] fifo_level;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] sb [$];
    logic [1:0] exp_dir;
    logic       exp_dir_v;
    logic [7:0] exp_drop;

    always #5 clk = ~clk;

    ctrl_cmd_arbiter #(.NUM_SRC(3), .FIFO_DEPTH(4), .DROP_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_up         (src_up),
        .src_down       (src_down),
        .src_left       (src_left),
        .src_right      (src_right),
        .src_start      (src_start),
        .src_en         (src_en),
        .cmd_valid      (cmd_valid),
        .cmd_code       (cmd_code),
        .cmd_src        (cmd_src),
        .cmd_ready      (cmd_ready),
        .dir_held       (dir_held),
        .dir_held_valid (dir_held_valid),
        .drop_cnt       (drop_cnt),
        .fifo_level     (fifo_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop();
        logic [4:0] e;
        check("pop_sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pop_code", 32'(cmd_code), 32'(e[2:0]));
            check("pop_src", 32'(cmd_src), 32'(e[4:3]));
            if (e[2:0] >= 3'd1 && e[2:0] <= 3'd4) begin
                exp_dir   = 2'(e[2:0] - 3'd1);
                exp_dir_v = 1'b1;
            end
        end
    endtask

    task automatic tick();
        if (cmd_valid && cmd_ready) check_pop();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulses();
        src_up = '0; src_down = '0; src_left = '0; src_right = '0; src_start = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        cmd_ready = 1'b1;
        while ((sb.size() != 0 || cmd_valid) && n < 60) begin
            tick();
            n++;
        end
        check("drain_done", 32'(sb.size() == 0 && !cmd_valid), 1);
        cmd_ready = 1'b0;
        check("dir_held", 32'(dir_held), 32'(exp_dir));
        check("dir_held_valid", 32'(dir_held_valid), 32'(exp_dir_v));
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_ready = 1'b0;
        clr_pulses();
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
        exp_dir = 2'd0; exp_dir_v = 1'b0; exp_drop = 8'd0;
    endtask

    initial begin
        rst_n = 1'b0; src_en = 3'b111; cmd_ready = 1'b0;
        clr_pulses();
        exp_dir = 2'd0; exp_dir_v = 1'b0; exp_drop = 8'd0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // reset in the middle of traffic discards everything
        src_up = 3'b001; src_down = 3'b010;
        tick();
        clr_pulses();
        tick();
        do_reset();
        check("rst_valid", 32'(cmd_valid), 0);
        check("rst_code", 32'(cmd_code), 0);
        check("rst_src", 32'(cmd_src), 0);
        check("rst_dir", 32'(dir_held), 0);
        check("rst_dir_v", 32'(dir_held_valid), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_level", 32'(fifo_level), 0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("rst_ready_valid", 32'(cmd_valid), 0);
        check("rst_ready_level", 32'(fifo_level), 0);
        check("rst_ready_dir_v", 32'(dir_held_valid), 0);

        // single source latency
        src_left = 3'b010;
        tick();
        clr_pulses();
        check("lat_pending_valid", 32'(cmd_valid), 0);
        tick();
        check("lat_valid", 32'(cmd_valid), 1);
        check("lat_code", 32'(cmd_code), 3);
        check("lat_src", 32'(cmd_src), 1);
        check("lat_level", 32'(fifo_level), 1);
        sb.push_back({2'd1, 3'd3});
        drain();

        // round robin from reset pointer, then repeated after pointer lands on 2
        do_reset();
        for (int r = 0; r < 2; r++) begin
            src_up = 3'b001; src_down = 3'b010; src_right = 3'b100;
            tick();
            clr_pulses();
            tick(); tick(); tick();
            check("rr_level", 32'(fifo_level), 3);
            check("rr_head_src", 32'(cmd_src), 0);
            sb.push_back({2'd0, 3'd1});
            sb.push_back({2'd1, 3'd2});
            sb.push_back({2'd2, 3'd4});
            drain();
        end

        // multi-bit pulse keeps START only
        src_start = 3'b001; src_up = 3'b001;
        tick();
        clr_pulses();
        exp_drop = 8'd1;
        check("multi_drop", 32'(drop_cnt), 1);
        sb.push_back({2'd0, 3'd5});
        drain();

        // fill the FIFO, then overwrite a pending entry while full
        src_up = 3'b001; src_down = 3'b010; src_left = 3'b100;
        tick();
        clr_pulses();
        tick(); tick(); tick();
        check("fill_level3", 32'(fifo_level), 3);
        sb.push_back({2'd1, 3'd2});
        sb.push_back({2'd2, 3'd3});
        sb.push_back({2'd0, 3'd1});
        src_right = 3'b001;
        tick();
        clr_pulses();
        tick();
        check("fill_level4", 32'(fifo_level), 4);
        sb.push_back({2'd0, 3'd4});
        src_start = 3'b100;
        tick();
        clr_pulses();
        src_up = 3'b100;
        tick();
        clr_pulses();
        exp_drop = 8'd2;
        check("ovwr_drop", 32'(drop_cnt), 2);
        check("full_level", 32'(fifo_level), 4);
        tick();
        check("full_no_grant", 32'(fifo_level), 4);
        sb.push_back({2'd2, 3'd1});
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("full_poppush_level", 32'(fifo_level), 4);
        check("full_head_code", 32'(cmd_code), 3);
        check("full_head_src", 32'(cmd_src), 2);
        drain();

        // enable mask
        src_en = 3'b101; src_right = 3'b010;
        tick();
        clr_pulses();
        tick();
        check("mask_valid", 32'(cmd_valid), 0);
        check("mask_level", 32'(fifo_level), 0);
        check("mask_drop", 32'(drop_cnt), 2);
        src_en = 3'b111; src_right = 3'b010;
        tick();
        clr_pulses();
        tick();
        check("unmask_valid", 32'(cmd_valid), 1);
        check("unmask_code", 32'(cmd_code), 4);
        check("unmask_src", 32'(cmd_src), 1);
        sb.push_back({2'd1, 3'd4});
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
